// File: rtl/regfile_mp_sb_pkg.sv
// Shared CPU datapath types plus register-file port defaults and the
// architectural zero-register index.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        logic [7:0] nread;
        logic [7:0] nwrite;
    } rf_port_cfg_t;

    localparam rf_port_cfg_t RF_PORT_CFG_DEFAULT = '{nread: 8'd2, nwrite: 8'd1};
    localparam int           REG_ZERO            = 0;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback side bundle of the register file: read ports, write
// ports, reservation and flush, with the busy answer per read port.
interface regfile_mp_sb_if #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // No valid/ready pairs: wen[w] and rsv_en qualify their select/data in the
    // cycle they are high and are always accepted; reads are combinational.
    logic [NREAD-1:0][AW-1:0]  rsel;
    logic [NREAD-1:0][DW-1:0]  rdat;
    logic [NREAD-1:0]          busy;
    logic [NWRITE-1:0]         wen;
    logic [NWRITE-1:0][AW-1:0] wsel;
    logic [NWRITE-1:0][DW-1:0] wdat;
    logic                      rsv_en;
    logic [AW-1:0]             rsv_sel;
    logic                      flush;

    modport master (
        output rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
        input  rdat, busy
    );

    modport slave (
        input  rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
        output rdat, busy
    );

endinterface

// File: rtl/regfile_mp_sb_rf_scoreboard.sv
// Per-register pending bits: flush beats reserve, reserve beats a clear from
// a same-cycle write, otherwise the bit holds.
module rf_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_sel,
    input  logic [DEPTH-1:0] clr,
    input  logic             flush,
    output logic [DEPTH-1:0] pending
);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_en && (rsv_sel == AW'(i)) && !(ZERO_REG && (i == REG_ZERO))) begin
                pending_d[i] = 1'b1;
            end else if (clr[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        if (flush) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-priority resolve, optional same-cycle
// bypass, optional hardwired zero register and an integrated scoreboard.
module regfile_mp_sb
    import cpu_types_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = int'(RF_PORT_CFG_DEFAULT.nread),
    parameter int NWRITE   = int'(RF_PORT_CFG_DEFAULT.nwrite),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input logic            CLK,
    input logic            nRST,
    regfile_mp_sb_if.slave rf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] win_en;
    logic [DW-1:0]    win_dat [DEPTH];
    logic [DEPTH-1:0] pending;

    // Later ports overwrite earlier ones, so the highest index wins. Writes are
    // masked during reset so the bypass path cannot leak data while nRST is low.
    always_comb begin
        win_en = '0;
        for (int a = 0; a < DEPTH; a++) begin
            win_dat[a] = '0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            for (int w = 0; w < NWRITE; w++) begin
                if (nRST && rf.wen[w] && (rf.wsel[w] == AW'(a)) &&
                    !(ZERO_REG && (a == REG_ZERO))) begin
                    win_en[a]  = 1'b1;
                    win_dat[a] = rf.wdat[w];
                end
            end
        end
    end

    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = win_en[a] ? win_dat[a] : mem_q[a];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= mem_d[a];
            end
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .CLK     (CLK),
        .nRST    (nRST),
        .rsv_en  (rf.rsv_en),
        .rsv_sel (rf.rsv_sel),
        .clr     (win_en),
        .flush   (rf.flush),
        .pending (pending)
    );

    // Selects beyond DEPTH never match an address and fall through to zero.
    always_comb begin
        rf.rdat = '0;
        rf.busy = '0;
        for (int r = 0; r < NREAD; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ((rf.rsel[r] == AW'(a)) && !(ZERO_REG && (a == REG_ZERO))) begin
                    rf.rdat[r] = mem_q[a];
                    rf.busy[r] = pending[a];
                    if (BYPASS && win_en[a]) begin
                        rf.rdat[r] = win_dat[a];
                        rf.busy[r] = 1'b0;
                    end
                end
            end
        end
    end

endmodule
